// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge/level capture, per-channel mask,
// and a single-level request / service handshake toward the core.
//
// state | meaning
// IDLE  | waiting for an unmasked pending channel
// REQ   | int_req high, id/vector frozen until int_ack
// SVC   | ISR running, no nesting, waiting for rti_done
module irq_controller #(
    parameter int                     NUM_IRQ   = 4,
    parameter int                     ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]      VEC_BASE  = 'h01,
    parameter logic [NUM_IRQ-1:0]     EDGE_MODE = '1,
    localparam int                    IDW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_din,
    output logic                int_req,
    output logic [IDW-1:0]      int_id,
    output logic [ADDR_W-1:0]   int_vec_addr,
    input  logic                int_ack,
    input  logic                rti_done,
    output logic                in_service,
    output logic [NUM_IRQ-1:0]  pending
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_int_req;
    logic [IDW-1:0]     r_int_id;
    logic [ADDR_W-1:0]  r_vec;
    logic               r_in_service;

    logic               w_ack_take;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [IDW-1:0]     w_sel_id;
    logic [ADDR_W-1:0]  w_sel_vec;

    assign w_ack_take = (r_state == ST_REQ) && int_ack;
    assign w_elig     = r_pending & ~r_mask;

    // A fresh rising edge wins over the acknowledge clear on the same channel.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MODE[i]) begin
                w_pending_nxt[i] = (irq_in[i] & ~r_irq_d[i]) |
                                   (r_pending[i] & ~(w_ack_take && (r_int_id == IDW'(i))));
            end else begin
                w_pending_nxt[i] = irq_in[i];
            end
        end
    end

    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) w_sel_id = IDW'(i);
        end
    end

    assign w_sel_vec = VEC_BASE + ADDR_W'(w_sel_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_irq_d      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_int_req    <= 1'b0;
            r_int_id     <= '0;
            r_vec        <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_irq_d   <= irq_in;
            r_pending <= w_pending_nxt;
            if (mask_we) r_mask <= mask_din;

            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_state   <= ST_REQ;
                        r_int_req <= 1'b1;
                        r_int_id  <= w_sel_id;
                        r_vec     <= w_sel_vec;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_state      <= ST_SVC;
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                ST_SVC: begin
                    if (rti_done) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign int_req      = r_int_req;
    assign int_id       = r_int_id;
    assign int_vec_addr = r_vec;
    assign in_service   = r_in_service;
    assign pending      = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller at default parameters; expected requests
// are queued when interrupts are driven and checked when int_req appears.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       int_req;
    logic [1:0] int_id;
    logic [7:0] int_vec_addr;
    logic       int_ack;
    logic       rti_done;
    logic       in_service;
    logic [3:0] pending;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] vec;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    bit   got;
    int   n_cmp = 0;
    int   n_bad = 0;

    irq_controller dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .mask_we      (mask_we),
        .mask_din     (mask_din),
        .int_req      (int_req),
        .int_id       (int_id),
        .int_vec_addr (int_vec_addr),
        .int_ack      (int_ack),
        .rti_done     (rti_done),
        .in_service   (in_service),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int ch);
        exp_t r;
        r.id  = 2'(ch);
        r.vec = 8'(8'h01 + ch);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (int_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_rti();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_din = '0;
        int_ack = 1'b0; rti_done = 1'b0;
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", int_req); end
        n_cmp++; if (int_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", int_id); end
        n_cmp++; if (int_vec_addr !== 8'h00) begin n_bad++; $display("FAIL reset_vec: got %h want 00", int_vec_addr); end
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL reset_insvc: got %b want 0", in_service); end
        n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL reset_pending: got %b want 0000", pending); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        irq_in = 4'b0100; sb_q.push_back(mk(2));
        tick();
        irq_in = '0;
        n_cmp++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL single_pend: got %b want 0100", pending); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL single_lat: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL single_id: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL single_vec: got %h want %h", int_vec_addr, e.vec); end
        do_ack();
        n_cmp++; if (in_service !== 1'b1) begin n_bad++; $display("FAIL single_insvc: got %b want 1", in_service); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL single_reqoff: got %b want 0", int_req); end
        n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL single_clr: got %b want 0000", pending); end
        tick();
        n_cmp++; if (int_id !== 2'd2) begin n_bad++; $display("FAIL single_idhold: got %0d want 2", int_id); end
        do_rti();
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL single_rti: got %b want 0", in_service); end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010; sb_q.push_back(mk(1)); sb_q.push_back(mk(3));
        tick();
        irq_in = '0;
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL prio_req: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL prio_id1: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL prio_vec1: got %h want %h", int_vec_addr, e.vec); end
        do_ack();
        n_cmp++; if (pending !== 4'b1000) begin n_bad++; $display("FAIL prio_pend: got %b want 1000", pending); end
        do_rti();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL prio_gap: got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL prio_req2: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL prio_id3: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL prio_vec3: got %h want %h", int_vec_addr, e.vec); end
        do_ack(); do_rti();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_din = 4'b0001;
        tick();
        mask_we = 1'b0;
        irq_in = 4'b0001;
        tick();
        irq_in = '0;
        tick(); tick();
        n_cmp++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL mask_pend: got %b want 0001", pending); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL mask_block: got %b want 0", int_req); end
        sb_q.push_back(mk(0));
        mask_we = 1'b1; mask_din = 4'b0000;
        tick();
        mask_we = 1'b0;
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL mask_load: got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL mask_req: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL mask_id: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL mask_vec: got %h want %h", int_vec_addr, e.vec); end
        do_ack(); do_rti();
    endtask

    task automatic test_no_preempt();
        irq_in = 4'b0100; sb_q.push_back(mk(2));
        tick();
        irq_in = '0;
        tick();
        irq_in = 4'b0001; sb_q.push_back(mk(0));
        mask_we = 1'b1; mask_din = 4'b0100;
        tick();
        irq_in = '0; mask_we = 1'b0;
        tick(); tick();
        e = sb_q.pop_front();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL hold_req: got %b want 1", int_req); end
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL hold_id: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL hold_vec: got %h want %h", int_vec_addr, e.vec); end
        do_ack();
        n_cmp++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL hold_pend: got %b want 0001", pending); end
        do_rti();
        wait_req(got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL hold_timeout: int_req %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL hold_id0: got %0d want %0d", int_id, e.id); end
        do_ack(); do_rti();
        mask_we = 1'b1; mask_din = 4'b0000;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic test_ack_race();
        irq_in = 4'b0010; sb_q.push_back(mk(1));
        tick();
        irq_in = '0;
        tick();
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL race_id: got %0d want %0d", int_id, e.id); end
        irq_in = 4'b0010; int_ack = 1'b1; sb_q.push_back(mk(1));
        tick();
        irq_in = '0; int_ack = 1'b0;
        n_cmp++; if (in_service !== 1'b1) begin n_bad++; $display("FAIL race_insvc: got %b want 1", in_service); end
        n_cmp++; if (pending !== 4'b0010) begin n_bad++; $display("FAIL race_pend: got %b want 0010", pending); end
        do_rti();
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL race_rereq: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL race_vec: got %h want %h", int_vec_addr, e.vec); end
        do_ack(); do_rti();
    endtask

    task automatic test_ignore();
        int_ack = 1'b1; rti_done = 1'b1;
        tick();
        int_ack = 1'b0; rti_done = 1'b0;
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL ign_ack: got %b want 0", in_service); end
        irq_in = 4'b1000; sb_q.push_back(mk(3));
        tick();
        irq_in = '0;
        tick();
        do_rti();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL ign_rti: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL ign_vec: got %h want %h", int_vec_addr, e.vec); end
        do_ack(); do_rti();
    endtask

    task automatic test_reset_mid();
        irq_in = 4'b0010; sb_q.push_back(mk(1));
        tick();
        irq_in = '0;
        tick();
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL rmid_id: got %0d want %0d", int_id, e.id); end
        do_ack();
        irq_in = 4'b0110;
        tick();
        n_cmp++; if (pending !== 4'b0110) begin n_bad++; $display("FAIL rmid_pend: got %b want 0110", pending); end
        irq_in = 4'b1000; rst = 1'b1;
        tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req: got %b want 0", int_req); end
        n_cmp++; if (int_id !== 2'd0) begin n_bad++; $display("FAIL rmid_idz: got %0d want 0", int_id); end
        n_cmp++; if (int_vec_addr !== 8'h00) begin n_bad++; $display("FAIL rmid_vec: got %h want 00", int_vec_addr); end
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL rmid_insvc: got %b want 0", in_service); end
        n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL rmid_pendz: got %b want 0000", pending); end
        rst = 1'b0; sb_q.push_back(mk(3));
        tick();
        n_cmp++; if (pending !== 4'b1000) begin n_bad++; $display("FAIL rmid_held: got %b want 1000", pending); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rmid_early: got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL rmid_rereq: got %b want 1", int_req); end
        e = sb_q.pop_front();
        n_cmp++; if (int_id !== e.id) begin n_bad++; $display("FAIL rmid_id3: got %0d want %0d", int_id, e.id); end
        n_cmp++; if (int_vec_addr !== e.vec) begin n_bad++; $display("FAIL rmid_vec3: got %h want %h", int_vec_addr, e.vec); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_no_preempt();
        test_ack_race();
        test_ignore();
        test_reset_mid();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

endmodule
